// File: rtl/axi2ahb_cmd_arb.sv
// AXI AW/AR round-robin command scheduler for the AXI-to-AHB bridge.
// Issues one command at a time to axi2ahb_ctrl and returns the B response for writes.
module axi2ahb_cmd_arb #(
   parameter int AXI_ADDR_WIDTH = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                      ACLK,
   input  logic                      ARESET,
   input  logic                      s_awvalid,
   output logic                      s_awready,
   input  logic [AXI_ADDR_WIDTH-1:0] s_awaddr,
   input  logic [7:0]                s_awlen,
   input  logic [1:0]                s_awburst,
   input  logic                      s_arvalid,
   output logic                      s_arready,
   input  logic [AXI_ADDR_WIDTH-1:0] s_araddr,
   input  logic [7:0]                s_arlen,
   input  logic [1:0]                s_arburst,
   output logic                      s_bvalid,
   input  logic                      s_bready,
   output logic [1:0]                s_bresp,
   output logic                      cmd_read_o,
   output logic                      cmd_write_o,
   output logic [AXI_ADDR_WIDTH-1:0] cmd_start_addr_o,
   output logic [7:0]                cmd_transfer_len_o,
   output logic [1:0]                cmd_burst_type_o,
   output logic                      ctrl_cmd_valid_o,
   input  logic                      ctrl_cmd_ready_i,
   output logic                      timeout_err_o
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, WRESP} state_t;

   localparam logic [15:0] TMO_LIM = TIMEOUT_CYCLES[15:0];
   localparam bit          TMO_EN  = (TIMEOUT_CYCLES != 0);

   state_t                    state_q, state_d;
   logic                      last_read_q, last_read_d;
   logic                      cmd_rd_q, cmd_rd_d;
   logic                      cmd_wr_q, cmd_wr_d;
   logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]                len_q, len_d;
   logic [1:0]                burst_q, burst_d;
   logic                      err_q, err_d;
   logic                      tmo_q, tmo_d;
   logic [15:0]               cnt_q, cnt_d;

   logic                      grant_w;
   logic                      aw_hs;
   logic                      ar_hs;
   logic [15:0]               cnt_inc;

   // Contested cycles go to whichever side did not win last time
   assign grant_w = s_awvalid & (~s_arvalid | last_read_q);
   assign aw_hs   = (state_q == IDLE) & grant_w;
   assign ar_hs   = (state_q == IDLE) & s_arvalid & ~grant_w;
   assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

   always_comb begin
      state_d     = state_q;
      last_read_d = last_read_q;
      cmd_rd_d    = cmd_rd_q;
      cmd_wr_d    = cmd_wr_q;
      addr_d      = addr_q;
      len_d       = len_q;
      burst_d     = burst_q;
      err_d       = err_q;
      tmo_d       = tmo_q;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE: begin
            if (aw_hs || ar_hs) begin
               addr_d      = aw_hs ? s_awaddr  : s_araddr;
               len_d       = aw_hs ? s_awlen   : s_arlen;
               burst_d     = aw_hs ? s_awburst : s_arburst;
               last_read_d = ar_hs;
               cmd_wr_d    = aw_hs;
               cmd_rd_d    = ar_hs;
               err_d       = 1'b0;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = 16'd0;
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            cnt_d = cnt_inc;
            // Timeout only flags the command; completion is still awaited
            if (TMO_EN && cnt_inc == TMO_LIM) begin
               tmo_d = 1'b1;
               err_d = 1'b1;
            end
            if (ctrl_cmd_ready_i) begin
               cmd_rd_d = 1'b0;
               cmd_wr_d = 1'b0;
               state_d  = cmd_wr_q ? WRESP : IDLE;
            end
         end
         WRESP: begin
            if (s_bready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q     <= IDLE;
         last_read_q <= 1'b1;
         cmd_rd_q    <= 1'b0;
         cmd_wr_q    <= 1'b0;
         addr_q      <= '0;
         len_q       <= '0;
         burst_q     <= '0;
         err_q       <= 1'b0;
         tmo_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         last_read_q <= last_read_d;
         cmd_rd_q    <= cmd_rd_d;
         cmd_wr_q    <= cmd_wr_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         burst_q     <= burst_d;
         err_q       <= err_d;
         tmo_q       <= tmo_d;
         cnt_q       <= cnt_d;
      end
   end

   assign s_awready          = aw_hs;
   assign s_arready          = ar_hs;
   assign s_bvalid           = (state_q == WRESP);
   assign s_bresp            = ((state_q == WRESP) && err_q) ? 2'b10 : 2'b00;
   assign ctrl_cmd_valid_o   = (state_q == ISSUE);
   assign cmd_read_o         = cmd_rd_q;
   assign cmd_write_o        = cmd_wr_q;
   assign cmd_start_addr_o   = addr_q;
   assign cmd_transfer_len_o = len_q;
   assign cmd_burst_type_o   = burst_q;
   assign timeout_err_o      = tmo_q;

endmodule

// File: tb/tb_axi2ahb_cmd_arb.sv
// Directed bench for axi2ahb_cmd_arb: transaction table plus hand sequences for
// timeout, B back-pressure and reset during a command.
module tb_axi2ahb_cmd_arb;

   logic       clk = 1'b0;
   logic       rst;
   logic       s_awvalid, s_awready;
   logic [7:0] s_awaddr, s_awlen;
   logic [1:0] s_awburst;
   logic       s_arvalid, s_arready;
   logic [7:0] s_araddr, s_arlen;
   logic [1:0] s_arburst;
   logic       s_bvalid, s_bready;
   logic [1:0] s_bresp;
   logic       cmd_read_o, cmd_write_o;
   logic [7:0] cmd_start_addr_o, cmd_transfer_len_o;
   logic [1:0] cmd_burst_type_o;
   logic       ctrl_cmd_valid_o, ctrl_cmd_ready_i, timeout_err_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   axi2ahb_cmd_arb #(.AXI_ADDR_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
      .ACLK(clk), .ARESET(rst),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
      .s_awlen(s_awlen), .s_awburst(s_awburst),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
      .s_arlen(s_arlen), .s_arburst(s_arburst),
      .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
      .cmd_read_o(cmd_read_o), .cmd_write_o(cmd_write_o),
      .cmd_start_addr_o(cmd_start_addr_o), .cmd_transfer_len_o(cmd_transfer_len_o),
      .cmd_burst_type_o(cmd_burst_type_o), .ctrl_cmd_valid_o(ctrl_cmd_valid_o),
      .ctrl_cmd_ready_i(ctrl_cmd_ready_i), .timeout_err_o(timeout_err_o)
   );

   typedef struct {
      logic       awv, arv;
      logic [7:0] awaddr, awlen;
      logic [1:0] awburst;
      logic [7:0] araddr, arlen;
      logic [1:0] arburst;
      int         delay;
      logic       exp_w;
      logic [7:0] exp_addr, exp_len;
      logic [1:0] exp_burst, exp_resp;
   } vec_t;

   vec_t tbl [10];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_awready"}, s_awready, 0);
      chk({tag, "_arready"}, s_arready, 0);
      chk({tag, "_bvalid"}, s_bvalid, 0);
      chk({tag, "_bresp"}, s_bresp, 0);
      chk({tag, "_cmd_rw"}, {cmd_read_o, cmd_write_o}, 0);
      chk({tag, "_addr"}, cmd_start_addr_o, 0);
      chk({tag, "_len"}, cmd_transfer_len_o, 0);
      chk({tag, "_burst"}, cmd_burst_type_o, 0);
      chk({tag, "_cmd_valid"}, ctrl_cmd_valid_o, 0);
      chk({tag, "_timeout"}, timeout_err_o, 0);
   endtask

   task automatic chk_fields(input vec_t v, input string tag);
      chk({tag, "_write"}, cmd_write_o, v.exp_w);
      chk({tag, "_read"}, cmd_read_o, !v.exp_w);
      chk({tag, "_addr"}, cmd_start_addr_o, v.exp_addr);
      chk({tag, "_len"}, cmd_transfer_len_o, v.exp_len);
      chk({tag, "_burst"}, cmd_burst_type_o, v.exp_burst);
      chk({tag, "_no_ready"}, {s_awready, s_arready}, 0);
   endtask

   // Entered just after a clock edge with the DUT in IDLE; leaves it in IDLE
   task automatic run_txn(input vec_t v);
      s_awvalid = v.awv; s_awaddr = v.awaddr; s_awlen = v.awlen; s_awburst = v.awburst;
      s_arvalid = v.arv; s_araddr = v.araddr; s_arlen = v.arlen; s_arburst = v.arburst;
      #1;
      chk("awready_grant", s_awready, v.exp_w);
      chk("arready_grant", s_arready, !v.exp_w);
      step();
      chk("cmd_valid_issue", ctrl_cmd_valid_o, 1);
      chk_fields(v, "issue");
      step();
      chk("cmd_valid_wait", ctrl_cmd_valid_o, 0);
      for (int i = 0; i < v.delay; i++) begin
         chk_fields(v, "wait");
         step();
      end
      chk_fields(v, "done_cycle");
      ctrl_cmd_ready_i = 1'b1;
      step();
      ctrl_cmd_ready_i = 1'b0;
      chk("cmd_rw_cleared", {cmd_read_o, cmd_write_o}, 0);
      chk("bvalid_after_done", s_bvalid, v.exp_w);
      if (v.exp_w) begin
         chk("bresp", s_bresp, v.exp_resp);
         s_bready = 1'b1;
         step();
         s_bready = 1'b0;
         chk("bvalid_after_hs", s_bvalid, 0);
      end
      s_awvalid = 1'b0;
      s_arvalid = 1'b0;
   endtask

   initial begin
      vec_t w;
      rst = 1'b1;
      s_awvalid = 0; s_awaddr = 0; s_awlen = 0; s_awburst = 0;
      s_arvalid = 0; s_araddr = 0; s_arlen = 0; s_arburst = 0;
      s_bready = 0; ctrl_cmd_ready_i = 0;

      //           awv  arv  awaddr awlen awb   araddr arlen arb   dly w     addr   len   burst resp
      tbl[0] = '{1'b1, 1'b0, 8'h40, 8'd3, 2'b01, 8'h00, 8'd0, 2'b00, 2, 1'b1, 8'h40, 8'd3, 2'b01, 2'b00};
      tbl[1] = '{1'b1, 1'b1, 8'h11, 8'd1, 2'b01, 8'h22, 8'd2, 2'b00, 1, 1'b0, 8'h22, 8'd2, 2'b00, 2'b00};
      tbl[2] = '{1'b1, 1'b1, 8'h11, 8'd1, 2'b01, 8'h22, 8'd2, 2'b00, 0, 1'b1, 8'h11, 8'd1, 2'b01, 2'b00};
      tbl[3] = '{1'b1, 1'b1, 8'h11, 8'd1, 2'b01, 8'h22, 8'd2, 2'b00, 3, 1'b0, 8'h22, 8'd2, 2'b00, 2'b00};
      tbl[4] = '{1'b1, 1'b1, 8'h11, 8'd1, 2'b01, 8'h22, 8'd2, 2'b00, 1, 1'b1, 8'h11, 8'd1, 2'b01, 2'b00};
      tbl[5] = '{1'b0, 1'b1, 8'h00, 8'd0, 2'b00, 8'h20, 8'd7, 2'b10, 5, 1'b0, 8'h20, 8'd7, 2'b10, 2'b00};
      tbl[6] = '{1'b1, 1'b1, 8'h5A, 8'd9, 2'b10, 8'hA5, 8'd4, 2'b01, 0, 1'b1, 8'h5A, 8'd9, 2'b10, 2'b00};
      tbl[7] = '{1'b0, 1'b1, 8'h00, 8'd0, 2'b00, 8'h33, 8'd0, 2'b00, 2, 1'b0, 8'h33, 8'd0, 2'b00, 2'b00};
      tbl[8] = '{1'b0, 1'b1, 8'h00, 8'd0, 2'b00, 8'h44, 8'd15, 2'b01, 1, 1'b0, 8'h44, 8'd15, 2'b01, 2'b00};
      tbl[9] = '{1'b1, 1'b0, 8'hF0, 8'd0, 2'b00, 8'h00, 8'd0, 2'b00, 4, 1'b1, 8'hF0, 8'd0, 2'b00, 2'b00};

      repeat (2) step();
      chk_all_zero("reset");
      rst = 1'b0;
      step();

      for (int t = 0; t < 10; t++) run_txn(tbl[t]);
      chk("timeout_clear_after_table", timeout_err_o, 0);

      // Completion withheld 20 cycles with a 16-cycle timeout
      s_awvalid = 1'b1; s_awaddr = 8'h80; s_awlen = 8'd1; s_awburst = 2'b01;
      step();
      s_awvalid = 1'b0;
      chk("tmo_issue", ctrl_cmd_valid_o, 1);
      step();
      for (int k = 1; k <= 20; k++) begin
         step();
         if (k == 15) chk("tmo_before_limit", timeout_err_o, 0);
         if (k == 16) chk("tmo_at_limit", timeout_err_o, 1);
      end
      chk("tmo_not_aborted", cmd_write_o, 1);
      chk("tmo_no_bvalid", s_bvalid, 0);
      ctrl_cmd_ready_i = 1'b1;
      step();
      ctrl_cmd_ready_i = 1'b0;
      chk("tmo_bvalid", s_bvalid, 1);
      chk("tmo_bresp", s_bresp, 2'b10);
      s_bready = 1'b1;
      step();
      s_bready = 1'b0;
      chk("tmo_sticky", timeout_err_o, 1);
      w = tbl[0];
      run_txn(w);
      chk("tmo_sticky_next", timeout_err_o, 1);

      // B channel held off for 5 cycles with both address channels requesting
      s_awvalid = 1'b1; s_awaddr = 8'h66; s_awlen = 8'd2; s_awburst = 2'b01;
      step();
      s_awvalid = 1'b0;
      step();
      ctrl_cmd_ready_i = 1'b1;
      step();
      ctrl_cmd_ready_i = 1'b0;
      s_awvalid = 1'b1; s_arvalid = 1'b1;
      s_araddr = 8'h77; s_arlen = 8'd1; s_arburst = 2'b00;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_bvalid_held", s_bvalid, 1);
         chk("bp_no_ready", {s_awready, s_arready}, 0);
         step();
      end
      s_bready = 1'b1;
      step();
      s_bready = 1'b0;
      chk("bp_bvalid_drop", s_bvalid, 0);
      chk("bp_idle_arready", s_arready, 1);
      chk("bp_idle_awready", s_awready, 0);
      s_awvalid = 1'b0; s_arvalid = 1'b0;

      // Reset in WAIT_DONE, then a stray completion pulse
      s_awvalid = 1'b1; s_awaddr = 8'h99; s_awlen = 8'd4; s_awburst = 2'b10;
      step();
      s_awvalid = 1'b0;
      step();
      step();
      chk("rst_pre_write", cmd_write_o, 1);
      #2;
      rst = 1'b1;
      #1;
      chk_all_zero("async_rst");
      step();
      rst = 1'b0;
      ctrl_cmd_ready_i = 1'b1;
      step();
      ctrl_cmd_ready_i = 1'b0;
      chk("spurious_cmd_rw", {cmd_read_o, cmd_write_o}, 0);
      chk("spurious_bvalid", s_bvalid, 0);
      chk("spurious_cmd_valid", ctrl_cmd_valid_o, 0);
      step();
      chk("spurious_bvalid_late", s_bvalid, 0);
      w = tbl[2];
      run_txn(w);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
